// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: owns the PC, reads instruction memory over req/ack,
// buffers words in a 2-entry FIFO and handles taken-branch redirects and discards.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        Clk,
  input  logic        Rst_n,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemAck,
  input  logic [31:0] imemData,
  output logic [31:0] instruction,
  output logic [31:0] pcPlus4,
  output logic        instValid,
  input  logic        decodeReady,
  input  logic        branchTaken,
  input  logic [31:0] branchTarget
);

  localparam logic [1:0] FULL = 2'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] req_addr;
  logic [1:0]  count;
  logic [1:0]  count_nx;
  logic [31:0] data_mem [2];
  logic [31:0] pcp4_mem [2];
  logic        rd_ptr;
  logic        wr_ptr;
  logic        push;
  logic        pop;
  logic [31:0] pc_inc;
  logic [31:0] target_al;

  always_comb begin
    pop       = (count != 2'd0) && decodeReady;
    push      = (state == REQ) && imemAck && !branchTaken;
    count_nx  = count + 2'(push) - 2'(pop);
    pc_inc    = pc + 32'd4;
    target_al = branchTarget & ~32'd3;
  end

  // Request address is latched on entry to REQ so it never moves mid-request,
  // including while an abandoned read drains in DISCARD.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      req_addr    <= RESET_PC;
      count       <= 2'd0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      data_mem[0] <= 32'd0;
      data_mem[1] <= 32'd0;
      pcp4_mem[0] <= 32'd0;
      pcp4_mem[1] <= 32'd0;
    end else if (branchTaken) begin
      pc     <= target_al;
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      if (state != IDLE && !imemAck) begin
        state <= DISCARD;
      end else begin
        state    <= REQ;
        req_addr <= target_al;
      end
    end else begin
      count <= count_nx;
      if (push) begin
        data_mem[wr_ptr] <= imemData;
        pcp4_mem[wr_ptr] <= pc_inc;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case (state)
        IDLE: begin
          if (count_nx < FULL) begin
            state    <= REQ;
            req_addr <= pc;
          end
        end
        REQ: begin
          if (imemAck) begin
            pc       <= pc_inc;
            req_addr <= pc_inc;
            if (count_nx >= FULL) state <= IDLE;
          end
        end
        DISCARD: begin
          if (imemAck) begin
            state    <= REQ;
            req_addr <= pc;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign imemReq     = (state != IDLE);
  assign imemAddr    = req_addr;
  assign instValid   = (count != 2'd0);
  assign instruction = data_mem[rd_ptr];
  assign pcPlus4     = pcp4_mem[rd_ptr];

  a_no_overflow: assert property (@(posedge Clk) disable iff (!Rst_n) !(push && count >= FULL));

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus randomized traffic, checked against
// a queue-based model of program order, FIFO occupancy and request stability.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        Clk;
  logic        Rst_n;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemAck;
  logic [31:0] imemData;
  logic [31:0] instruction;
  logic [31:0] pcPlus4;
  logic        instValid;
  logic        decodeReady;
  logic        branchTaken;
  logic [31:0] branchTarget;

  int checks   = 0;
  int failures = 0;
  int pops     = 0;

  logic [31:0] q[$];
  logic [31:0] next_pc;
  logic        dead;
  logic        prev_wait;
  logic [31:0] prev_addr;
  logic [31:0] saved;

  fetch_stage #(.RESET_PC(RESET_PC), .FIFO_DEPTH(2)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .imemReq(imemReq), .imemAddr(imemAddr), .imemAck(imemAck), .imemData(imemData),
    .instruction(instruction), .pcPlus4(pcPlus4), .instValid(instValid),
    .decodeReady(decodeReady), .branchTaken(branchTaken), .branchTarget(branchTarget)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    next_pc   = RESET_PC;
    dead      = 1'b0;
    prev_wait = 1'b0;
    prev_addr = RESET_PC;
  endtask

  // One clock cycle: called at a negedge with inputs already applied.
  task automatic cyc();
    logic ack;
    logic pop;
    imemData = memf(imemAddr);
    chk("inst_valid", 32'(instValid), 32'(q.size() != 0));
    if (q.size() == 2) chk("full_no_req", 32'(imemReq), 32'd0);
    if (prev_wait) begin
      chk("req_held", 32'(imemReq), 32'd1);
      chk("addr_held", imemAddr, prev_addr);
    end
    ack = imemReq && imemAck;
    pop = instValid && decodeReady;
    if (branchTaken) begin
      q.delete();
      next_pc = branchTarget & ~32'd3;
      dead    = imemReq && !imemAck;
    end else begin
      if (pop && q.size() != 0) begin
        chk("pop_instr", instruction, memf(q[0]));
        chk("pop_pcplus4", pcPlus4, q[0] + 32'd4);
        void'(q.pop_front());
        pops++;
      end
      if (ack) begin
        if (dead) dead = 1'b0;
        else begin
          chk("fetch_addr", imemAddr, next_pc);
          q.push_back(imemAddr);
          next_pc = next_pc + 32'd4;
        end
      end
    end
    prev_wait = imemReq && !imemAck;
    prev_addr = imemAddr;
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic drive(input logic ack, input logic rdy, input logic br, input logic [31:0] tgt);
    imemAck      = ack && imemReq;
    decodeReady  = rdy;
    branchTaken  = br;
    branchTarget = tgt;
    cyc();
  endtask

  initial begin
    Rst_n = 1'b0; imemAck = 1'b0; imemData = 32'd0;
    decodeReady = 1'b0; branchTaken = 1'b0; branchTarget = 32'd0;
    model_reset();
    @(negedge Clk);
    chk("rst_req", 32'(imemReq), 32'd0);
    chk("rst_addr", imemAddr, RESET_PC);
    chk("rst_valid", 32'(instValid), 32'd0);
    chk("rst_instr", instruction, 32'd0);
    chk("rst_pcplus4", pcPlus4, 32'd0);
    @(negedge Clk);
    Rst_n = 1'b1;

    drive(1'b0, 1'b1, 1'b0, 32'd0);
    chk("first_req", 32'(imemReq), 32'd1);
    chk("first_addr", imemAddr, RESET_PC);

    // Streaming: ack every cycle, decode always ready.
    for (int i = 0; i < 6; i++) begin
      chk("seq_addr", imemAddr, 32'(4 * i));
      drive(1'b1, 1'b1, 1'b0, 32'd0);
      chk("seq_valid", 32'(instValid), 32'd1);
    end

    // Decode stalls: FIFO fills and requests stop, then drains in order.
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b0, 32'd0);
    chk("stall_req_off", 32'(imemReq), 32'd0);
    chk("stall_valid", 32'(instValid), 32'd1);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0, 32'd0);
    chk("resume_req", 32'(imemReq), 32'd1);
    chk("drained", 32'(instValid), 32'd0);

    // Slow memory: ack after 3 waiting cycles.
    saved = imemAddr;
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0, 32'd0);
    chk("slow_addr", imemAddr, saved);
    drive(1'b1, 1'b1, 1'b0, 32'd0);
    chk("slow_push", 32'(instValid), 32'd1);

    // Branch while a request is outstanding: late word dropped.
    saved = imemAddr;
    drive(1'b0, 1'b1, 1'b1, 32'h0000_0103);
    chk("disc_req", 32'(imemReq), 32'd1);
    chk("disc_old_addr", imemAddr, saved);
    chk("disc_flushed", 32'(instValid), 32'd0);
    drive(1'b0, 1'b1, 1'b0, 32'd0);
    drive(1'b1, 1'b1, 1'b0, 32'd0);
    chk("disc_new_addr", imemAddr, 32'h0000_0100);
    chk("disc_empty", 32'(instValid), 32'd0);

    // Branch coinciding with ack and pop.
    drive(1'b1, 1'b1, 1'b0, 32'd0);
    drive(1'b1, 1'b1, 1'b0, 32'd0);
    chk("pre_br_valid", 32'(instValid), 32'd1);
    drive(1'b1, 1'b1, 1'b1, 32'h0000_0200);
    chk("br_ack_valid", 32'(instValid), 32'd0);
    chk("br_ack_addr", imemAddr, 32'h0000_0200);
    chk("br_ack_req", 32'(imemReq), 32'd1);

    // PC wrap at the top of the address space.
    drive(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF);
    drive(1'b1, 1'b0, 1'b0, 32'd0);
    chk("wrap_addr", imemAddr, 32'hFFFF_FFFC);
    drive(1'b1, 1'b0, 1'b0, 32'd0);
    chk("wrap_valid", 32'(instValid), 32'd1);
    chk("wrap_pcplus4", pcPlus4, 32'd0);
    chk("wrap_instr", instruction, memf(32'hFFFF_FFFC));
    chk("wrap_next_addr", imemAddr, 32'd0);
    drive(1'b0, 1'b1, 1'b0, 32'd0);

    // Randomized traffic against the model.
    pops = 0;
    for (int i = 0; i < 600; i++) begin
      drive(($urandom % 10) < 6, ($urandom % 10) < 7, ($urandom % 20) == 0, $urandom);
    end
    chk("progress", 32'(pops > 30), 32'd1);

    // Reset in the middle of a request.
    for (int i = 0; i < 10 && !imemReq; i++) drive(1'b0, 1'b1, 1'b0, 32'd0);
    chk("pre_rst_req", 32'(imemReq), 32'd1);
    imemAck = 1'b0; branchTaken = 1'b0;
    Rst_n = 1'b0;
    #1;
    chk("mid_rst_req", 32'(imemReq), 32'd0);
    chk("mid_rst_addr", imemAddr, RESET_PC);
    chk("mid_rst_valid", 32'(instValid), 32'd0);
    chk("mid_rst_instr", instruction, 32'd0);
    chk("mid_rst_pcplus4", pcPlus4, 32'd0);
    model_reset();
    @(negedge Clk);
    Rst_n = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 32'd0);
    chk("post_rst_req", 32'(imemReq), 32'd1);
    chk("post_rst_addr", imemAddr, RESET_PC);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 1'b0, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
